// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM encoding and pipeline timing defaults
// used by the hazard unit, multiplier and branch unit.
package cpu_pkg;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_LDUSE = 2'd1,
      HZ_MULT  = 2'd2,
      HZ_FLUSH = 2'd3
   } hz_state_t;

   localparam int unsigned ADDR_RFILE_DEF = 5;
   localparam int unsigned MULT_LAT_DEF   = 4;
   localparam int unsigned FLUSH_CYC_DEF  = 2;

   // Width of a down-counter shared by two windows, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      int unsigned w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Source-vs-destination register comparator; register 0 never matches.
// Output bit [1] is the rs match, bit [0] the rt match.
module hazard_cmp
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_RFILE_DEF
) (
   input  logic [ADDR_W-1:0] addr_rs,
   input  logic [ADDR_W-1:0] addr_rt,
   input  logic              use_rs,
   input  logic              use_rt,
   input  logic [ADDR_W-1:0] addr_dst,
   output logic [1:0]        match
);

   logic dst_nz;

   always_comb begin
      dst_nz   = (addr_dst != '0);
      match[1] = dst_nz & use_rs & (addr_rs == addr_dst);
      match[0] = dst_nz & use_rt & (addr_rt == addr_dst);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and pipeline-control generator: load-use bubble,
// multi-cycle multiply hold and taken-branch flush window.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_RFILE = ADDR_RFILE_DEF,
   parameter int unsigned MULT_LAT   = MULT_LAT_DEF,
   parameter int unsigned FLUSH_CYC  = FLUSH_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_RFILE-1:0] addr_rs_id,
   input  logic [ADDR_RFILE-1:0] addr_rt_id,
   input  logic                  use_rs_id,
   input  logic                  use_rt_id,
   input  logic                  mult_sel_id,
   input  logic                  mem_r_ex,
   input  logic [ADDR_RFILE-1:0] addr_dst_ex,
   input  logic                  branch_taken_ex,
   output logic                  pc_hold,
   output logic                  ifid_hold,
   output logic                  stall_ctrl,
   output logic [1:0]            stall_ctrl_ab,
   output logic                  flush_ctrl,
   output logic                  busy
);

   localparam int unsigned CNT_W = cnt_width(MULT_LAT, FLUSH_CYC);
   localparam logic [CNT_W-1:0] MULT_LOAD  = CNT_W'(MULT_LAT - 2);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = (FLUSH_CYC > 1) ? CNT_W'(FLUSH_CYC - 2) : '0;

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       match;
   logic             lu;

   hazard_cmp #(
      .ADDR_W (ADDR_RFILE)
   ) u_cmp (
      .addr_rs  (addr_rs_id),
      .addr_rt  (addr_rt_id),
      .use_rs   (use_rs_id),
      .use_rt   (use_rt_id),
      .addr_dst (addr_dst_ex),
      .match    (match)
   );

   assign lu = mem_r_ex & (|match);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_hold       = 1'b0;
      ifid_hold     = 1'b0;
      stall_ctrl    = 1'b0;
      stall_ctrl_ab = 2'b00;
      flush_ctrl    = 1'b0;
      busy          = 1'b0;

      unique case (state_q)
         HZ_RUN: begin
            if (branch_taken_ex) begin
               flush_ctrl = 1'b1;
               if (FLUSH_CYC > 1) begin
                  state_d = HZ_FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
            end else if (lu) begin
               stall_ctrl    = 1'b1;
               pc_hold       = 1'b1;
               ifid_hold     = 1'b1;
               stall_ctrl_ab = match;
               state_d       = HZ_LDUSE;
            end else if (mult_sel_id) begin
               state_d = HZ_MULT;
               cnt_d   = MULT_LOAD;
            end
         end

         // The bubble still carries the held instruction's mem_r, so lu is masked here.
         HZ_LDUSE: begin
            state_d = HZ_RUN;
         end

         HZ_MULT: begin
            busy      = 1'b1;
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            if (cnt_q == '0) begin
               state_d = HZ_RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         HZ_FLUSH: begin
            flush_ctrl = 1'b1;
            if (branch_taken_ex) begin
               cnt_d = FLUSH_LOAD;
            end else if (cnt_q == '0) begin
               state_d = HZ_RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = HZ_RUN;
            cnt_d   = '0;
         end
      endcase

      // Outputs are combinational, so reset must gate them directly.
      if (!rst_n) begin
         pc_hold       = 1'b0;
         ifid_hold     = 1'b0;
         stall_ctrl    = 1'b0;
         stall_ctrl_ab = 2'b00;
         flush_ctrl    = 1'b0;
         busy          = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= HZ_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a remaining-cycles model.
module tb_hazard_ctrl;

   localparam int unsigned AW        = 5;
   localparam int unsigned MULT_LAT  = 4;
   localparam int unsigned FLUSH_CYC = 2;

   // Bit positions of the packed output vector.
   localparam int PC = 6, IF = 5, ST = 4, AB1 = 3, AB0 = 2, FL = 1, BU = 0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] rs, rt, dst;
   logic          urs, urt, mult, memr, br;
   logic          pc_hold, ifid_hold, stall_ctrl, flush_ctrl, busy;
   logic [1:0]    stall_ctrl_ab;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: cycles still owed to each activity.
   int m_busy  = 0;
   int m_bub   = 0;
   int m_flush = 0;

   logic [6:0] last_out;

   hazard_ctrl #(
      .ADDR_RFILE (AW),
      .MULT_LAT   (MULT_LAT),
      .FLUSH_CYC  (FLUSH_CYC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .addr_rs_id      (rs),
      .addr_rt_id      (rt),
      .use_rs_id       (urs),
      .use_rt_id       (urt),
      .mult_sel_id     (mult),
      .mem_r_ex        (memr),
      .addr_dst_ex     (dst),
      .branch_taken_ex (br),
      .pc_hold         (pc_hold),
      .ifid_hold       (ifid_hold),
      .stall_ctrl      (stall_ctrl),
      .stall_ctrl_ab   (stall_ctrl_ab),
      .flush_ctrl      (flush_ctrl),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] out_vec();
      return {pc_hold, ifid_hold, stall_ctrl, stall_ctrl_ab, flush_ctrl, busy};
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b (pc,ifid,stall,ab[1:0],flush,busy)",
                  name, $time, act, exp);
      end
   endtask

   // Expected outputs for this cycle, then advance the model across the coming edge.
   task automatic model_cycle(output logic [6:0] e);
      logic ms, mt;
      e  = '0;
      ms = urs && (rs == dst) && (dst != 0);
      mt = urt && (rt == dst) && (dst != 0);
      if (!rst_n) begin
         m_busy = 0; m_bub = 0; m_flush = 0;
      end else if (m_busy > 0) begin
         e[PC] = 1'b1; e[IF] = 1'b1; e[BU] = 1'b1;
         m_busy--;
      end else if (m_bub > 0) begin
         m_bub = 0;
      end else if (m_flush > 0) begin
         e[FL] = 1'b1;
         if (br) m_flush = FLUSH_CYC - 1;
         else    m_flush--;
      end else if (br) begin
         e[FL]   = 1'b1;
         m_flush = FLUSH_CYC - 1;
      end else if (memr && (ms || mt)) begin
         e[PC] = 1'b1; e[IF] = 1'b1; e[ST] = 1'b1;
         e[AB1] = ms; e[AB0] = mt;
         m_bub = 1;
      end else if (mult) begin
         m_busy = MULT_LAT - 1;
      end
   endtask

   task automatic cycle();
      logic [6:0] e;
      @(negedge clk);
      last_out = out_vec();
      model_cycle(e);
      chk("model", last_out, e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs = '0; rt = '0; dst = '0;
      urs = 1'b0; urt = 1'b0; mult = 1'b0; memr = 1'b0; br = 1'b0;
   endtask

   task automatic set_lu(input logic [AW-1:0] d, input logic [AW-1:0] s, input logic [AW-1:0] t,
                         input logic us, input logic ut);
      memr = 1'b1; dst = d; rs = s; rt = t; urs = us; urt = ut;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      cycle(); chk("reset_outputs", last_out, 7'b0000000);
      cycle(); chk("reset_outputs2", last_out, 7'b0000000);
      rst_n = 1'b1;
      cycle(); chk("idle_run", last_out, 7'b0000000);

      // Load-use on rs, then the masked bubble cycle.
      set_lu(5, 5, 0, 1'b1, 1'b0);
      cycle(); chk("lduse_rs", last_out, 7'b1111000);
      cycle(); chk("lduse_bubble", last_out, 7'b0000000);
      idle(); cycle();

      // Load-use on both operands.
      set_lu(7, 7, 7, 1'b1, 1'b1);
      cycle(); chk("lduse_both", last_out, 7'b1111100);
      idle();
      cycle(); chk("lduse_both_bubble", last_out, 7'b0000000);

      // Load-use on rt only; rs matching but unused must not count.
      set_lu(9, 9, 9, 1'b0, 1'b1);
      cycle(); chk("lduse_rt", last_out, 7'b1110100);
      idle(); cycle();

      // Register 0 never hazards.
      set_lu(0, 0, 0, 1'b1, 1'b1);
      cycle(); chk("zero_reg", last_out, 7'b0000000);
      idle(); cycle();

      // Multiply: entry cycle not stalled, then MULT_LAT-1 busy cycles; branch ignored.
      mult = 1'b1;
      cycle(); chk("mult_entry", last_out, 7'b0000000);
      mult = 1'b0;
      cycle(); chk("mult_busy1", last_out, 7'b1100001);
      br = 1'b1;
      cycle(); chk("mult_busy2_br", last_out, 7'b1100001);
      br = 1'b0;
      cycle(); chk("mult_busy3", last_out, 7'b1100001);
      cycle(); chk("mult_done", last_out, 7'b0000000);

      // Priority: branch over load-use over multiply.
      br = 1'b1; mult = 1'b1; set_lu(5, 5, 0, 1'b1, 1'b0);
      cycle(); chk("prio_flush1", last_out, 7'b0000010);
      br = 1'b0;
      cycle(); chk("prio_flush2", last_out, 7'b0000010);
      idle();
      cycle(); chk("prio_done", last_out, 7'b0000000);

      // Back-to-back branches extend the window.
      br = 1'b1;
      cycle(); chk("b2b_c0", last_out, 7'b0000010);
      cycle(); chk("b2b_c1", last_out, 7'b0000010);
      br = 1'b0;
      cycle(); chk("b2b_c2", last_out, 7'b0000010);
      cycle(); chk("b2b_c3", last_out, 7'b0000000);

      // Reset during the second MULT cycle.
      mult = 1'b1;
      cycle();
      mult = 1'b0;
      cycle(); chk("rst_mult1", last_out, 7'b1100001);
      rst_n = 1'b0;
      cycle(); chk("rst_mid_mult", last_out, 7'b0000000);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(); chk("rst_after", last_out, 7'b0000000);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         rs    = AW'($urandom_range(0, 3));
         rt    = AW'($urandom_range(0, 3));
         dst   = AW'($urandom_range(0, 3));
         urs   = $urandom_range(0, 1) != 0;
         urt   = $urandom_range(0, 1) != 0;
         memr  = $urandom_range(0, 1) != 0;
         br    = $urandom_range(0, 7) == 0;
         mult  = $urandom_range(0, 5) == 0;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard detection and pipeline-control generator for the 5-stage CPU. It drives the stall and flush controls that the ID/EX pipeline register consumes. Its inputs are the ID-stage operand addresses and the EX-stage fields already latched in ID/EX. It resolves three hazards:
- load-use, by inserting one bubble;
- multi-cycle multiply, by holding the front end;
- taken branch, by squashing wrong-path instructions for a fixed window.

## Interface
Parameters:
- ADDR_RFILE, 5, register-file address width
- MULT_LAT, 4, cycles a multiply occupies EX; must be ≥2
- FLUSH_CYC, 2, cycles flush_ctrl stays asserted per taken branch; must be ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- addr_rs_id  in  ADDR_RFILE  rs of instruction in ID
- addr_rt_id  in  ADDR_RFILE  rt of instruction in ID
- use_rs_id  in  1  ID instruction reads rs
- use_rt_id  in  1  ID instruction reads rt
- mult_sel_id  in  1  ID instruction is a multiply
- mem_r_ex  in  1  EX instruction is a load (mem_r from ID/EX)
- addr_dst_ex  in  ADDR_RFILE  EX destination register (post rfile_dst select)
- branch_taken_ex  in  1  branch in EX resolved taken
- pc_hold  out  1  freeze PC
- ifid_hold  out  1  freeze IF/ID register
- stall_ctrl  out  1  ID/EX inserts bubble (kills rfile_w, mem_w)
- stall_ctrl_ab  out  2  hazard source: [1] rs, [0] rt
- flush_ctrl  out  1  squash wrong-path instructions in IF/ID and ID/EX
- busy  out  1  multiply occupying EX; ID/EX and EX/MEM capture held externally

## Operation
- FSM states: RUN, LDUSE, MULT, FLUSH. Down-counter cnt is shared by MULT and FLUSH.
- Load-use term lu = mem_r_ex & (addr_dst_ex != 0) & ((use_rs_id & addr_rs_id == addr_dst_ex) | (use_rt_id & addr_rt_id == addr_dst_ex)). Register 0 never produces a hazard.
- Priority in RUN: branch_taken_ex > lu > mult_sel_id.
- RUN, branch_taken_ex=1:
  - flush_ctrl=1 in the same cycle.
  - If FLUSH_CYC>1: go to FLUSH with cnt=FLUSH_CYC-2. Otherwise stay in RUN.
- RUN, lu=1 (no branch):
  - stall_ctrl=pc_hold=ifid_hold=1 in the same cycle.
  - stall_ctrl_ab = {rs match, rt match}; both bits may be set.
  - Next state LDUSE.
- RUN, mult_sel_id=1 (no branch, no lu):
  - No stall in that cycle; the multiply advances into EX.
  - Next state MULT with cnt=MULT_LAT-2.
- LDUSE: all outputs 0. lu is masked, because the bubble in ID/EX still carries the held instruction's mem_r. Returns to RUN unconditionally.
- MULT: busy=pc_hold=ifid_hold=1 and stall_ctrl=0. branch_taken_ex and lu are ignored. When cnt==0, return to RUN; otherwise decrement cnt.
- FLUSH: flush_ctrl=1. lu and mult_sel_id are masked (wrong path). A new branch_taken_ex reloads cnt=FLUSH_CYC-2. Return to RUN when cnt==0.
- stall_ctrl_ab is 2'b00 whenever stall_ctrl=0.
- A multiply blocked by lu is re-evaluated after LDUSE, because ID is held; it then enters MULT.

## Timing
- State and cnt are registered. All outputs are combinational from state, cnt and current inputs; there is no output register.
- Reset: while rst_n=0, every output is 0; on the next edge state=RUN and cnt=0. Reset mid-MULT or mid-FLUSH aborts to RUN with no residual assertion.
- Load-use: exactly one bubble cycle. The dependent instruction enters EX two cycles after detection, with the load now in MEM for forwarding.
- Multiply: busy is high for cycles T+1..T+MULT_LAT-1 after entry edge T, giving MULT_LAT-1 cycles total.
- Branch: flush_ctrl is high for exactly FLUSH_CYC consecutive cycles, starting in the detection cycle.
- cnt width is $clog2(max(MULT_LAT, FLUSH_CYC)), minimum 1 bit.

## Structure
- Shared package cpu_pkg:
  - state encoding typedef/localparams HZ_RUN, HZ_LDUSE, HZ_MULT, HZ_FLUSH
  - ADDR_RFILE default
  - MULT_LAT and FLUSH_CYC defaults, shared with the multiplier and branch unit
- One natural sub-module: hazard_cmp. It is the combinational rs/rt-vs-dst comparator producing the 2-bit match vector, and is reused later by the forwarding unit.
- Everything else stays flat in hazard_ctrl.

## Test plan
- Load-use:
  - Stimulus: mem_r_ex=1, addr_dst_ex=5, addr_rs_id=5, use_rs_id=1.
  - Required: stall_ctrl=pc_hold=ifid_hold=1 and stall_ctrl_ab=2'b10 for one cycle. Next cycle all outputs 0 even though mem_r_ex=1 and addr match persist.
- Zero register: mem_r_ex=1, addr_dst_ex=0, addr_rs_id=addr_rt_id=0, both use=1 → no stall, all outputs 0.
- Multiply: mult_sel_id=1 for one cycle in RUN → busy/pc_hold/ifid_hold high for exactly 3 cycles (MULT_LAT=4), then RUN; a branch_taken_ex pulse in MULT has no effect.
- Priority:
  - Stimulus: branch_taken_ex=1 together with lu=1 and mult_sel_id=1.
  - Required: flush_ctrl=1 for 2 cycles, stall_ctrl=0 and busy=0 throughout; lu asserted in the second cycle is ignored.
- Back-to-back branches: branch_taken_ex in cycles 0 and 1 → flush_ctrl high for cycles 0–2 (3 cycles), then 0.
- Reset mid-operation: rst_n=0 asserted during the second MULT cycle → busy=0 immediately; after release with idle inputs, all outputs stay 0.
